// File: rtl/readout_scan.sv
// Zero-suppressed bus readout: scans N_SLOTS slot addresses, stores {slot, data}
// for every slot whose data exceeds thresh, and serves the stored hits to a host.
module readout_scan #(
    parameter int N_SLOTS = 256,
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int DEPTH   = 256,
    parameter int HAW     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DW-1:0]      thresh,
    output logic [AW-1:0]      addr,
    input  logic [DW-1:0]      data,
    input  logic               sel,
    input  logic [HAW-1:0]     haddr,
    output logic               busy,
    output logic               done,
    output logic [AW+DW-1:0]   hdata,
    output logic [HAW:0]       hnhit,
    output logic               ovf
);

    // state | meaning
    // IDLE  | waiting for start
    // SCAN  | driving slot addresses 0..N_SLOTS-1
    // DRAIN | evaluating data returned for the last slot
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [HAW:0]  DEPTH_C = DEPTH[HAW:0];
    localparam logic [AW-1:0] LAST_C  = AW'(N_SLOTS - 1);

    state_t            state, state_nx;
    logic [AW-1:0]     slot_q;
    logic              eval_q;
    logic              last_slot;
    logic              start_scan;
    logic              hit;
    logic              room;
    logic [AW+DW-1:0]  mem [DEPTH];

    assign last_slot  = (addr == LAST_C);
    assign start_scan = (state == IDLE) && start;
    assign hit        = eval_q && (data > thresh);
    assign room       = (hnhit < DEPTH_C);
    assign busy       = (state == SCAN) || (state == DRAIN);
    assign done       = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (last_slot) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            slot_q <= '0;
            eval_q <= 1'b0;
            hnhit  <= '0;
            ovf    <= 1'b0;
            hdata  <= '0;
        end else begin
            state  <= state_nx;
            addr   <= (state == SCAN && !last_slot) ? addr + 1'b1 : '0;
            // data arriving next cycle belongs to the slot driven now
            slot_q <= addr;
            eval_q <= (state == SCAN);
            if (start_scan) begin
                hnhit <= '0;
                ovf   <= 1'b0;
            end else if (hit) begin
                if (room) hnhit <= hnhit + 1'b1;
                else      ovf   <= 1'b1;
            end
            hdata <= (sel && !busy && ({1'b0, haddr} < hnhit)) ? mem[haddr] : '0;
        end
    end

    // Buffer is not reset; reads are gated by hnhit so stale entries never leak.
    always_ff @(posedge clk) begin
        if (rst_n && hit && room)
            mem[hnhit[HAW-1:0]] <= {slot_q, data};
    end

endmodule

// File: tb/tb_readout_scan.sv
// Directed bench for readout_scan with an 8-slot bus model and a 4-entry hit buffer.
module tb_readout_scan;
    localparam int N_SLOTS = 8;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int HAW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DW-1:0]     thresh = '0;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data = '0;
    logic              sel = 1'b0;
    logic [HAW-1:0]    haddr = '0;
    logic              busy;
    logic              done;
    logic [AW+DW-1:0]  hdata;
    logic [HAW:0]      hnhit;
    logic              ovf;

    logic [DW-1:0]     slot_mem [N_SLOTS];
    int                tests = 0;
    int                fails = 0;

    readout_scan #(.N_SLOTS(N_SLOTS), .AW(AW), .DW(DW), .DEPTH(DEPTH), .HAW(HAW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh), .addr(addr),
        .data(data), .sel(sel), .haddr(haddr), .busy(busy), .done(done),
        .hdata(hdata), .hnhit(hnhit), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // slot bus: data returns one cycle after the address
    always @(posedge clk) data <= slot_mem[addr];

    task automatic load_slots(input int v0, v1, v2, v3, v4, v5, v6, v7);
        slot_mem[0] = DW'(v0); slot_mem[1] = DW'(v1); slot_mem[2] = DW'(v2); slot_mem[3] = DW'(v3);
        slot_mem[4] = DW'(v4); slot_mem[5] = DW'(v5); slot_mem[6] = DW'(v6); slot_mem[7] = DW'(v7);
    endtask

    task automatic do_read(input logic s, input int idx, output logic [AW+DW-1:0] r);
        @(negedge clk);
        sel = s;
        haddr = HAW'(idx);
        @(negedge clk);
        r = hdata;
        sel = 1'b0;
    endtask

    // one-cycle start, then checks busy length, done pulse and addr sequence
    task automatic run_scan(input string name);
        int busy_cnt = 0;
        int done_cnt = 0;
        int addr_bad = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) begin
                if (busy_cnt < N_SLOTS && addr !== AW'(busy_cnt)) addr_bad++;
                if (busy_cnt == N_SLOTS && addr !== '0) addr_bad++;
                busy_cnt++;
            end else if (addr !== '0) addr_bad++;
            if (done) begin
                done_cnt++;
                if (busy_cnt != N_SLOTS + 1) addr_bad++;
            end
        end
        tests++;
        if (busy_cnt != 9) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d expected 9", name, busy_cnt);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        tests++;
        if (addr_bad != 0) begin
            fails++;
            $display("FAIL %s addr_sequence: got %0d bad cycles expected 0", name, addr_bad);
        end
    endtask

    task automatic check_counts(input string name, input int exp_n, input logic exp_o);
        tests++;
        if (hnhit !== (HAW+1)'(exp_n) || ovf !== exp_o) begin
            fails++;
            $display("FAIL %s counts: got hnhit=%0d ovf=%b expected hnhit=%0d ovf=%b",
                     name, hnhit, ovf, exp_n, exp_o);
        end
    endtask

    task automatic check_read(input string name, input logic s, input int idx,
                              input logic [AW+DW-1:0] exp_v);
        logic [AW+DW-1:0] r;
        do_read(s, idx, r);
        tests++;
        if (r !== exp_v) begin
            fails++;
            $display("FAIL %s read[%0d]: got %h expected %h", name, idx, r, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (addr !== '0 || busy !== 1'b0 || done !== 1'b0 || hdata !== '0 ||
            hnhit !== '0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: got addr=%0d busy=%b done=%b hdata=%h hnhit=%0d ovf=%b expected all 0",
                     addr, busy, done, hdata, hnhit, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sparse();
        load_slots(0, 5, 0, 9, 0, 0, 7, 0);
        thresh = 16'd0;
        run_scan("sparse");
        check_counts("sparse", 3, 1'b0);
        check_read("sparse", 1'b1, 0, {3'd1, 16'd5});
        check_read("sparse", 1'b1, 1, {3'd3, 16'd9});
        check_read("sparse", 1'b1, 2, {3'd6, 16'd7});
        check_read("sparse", 1'b1, 3, '0);
    endtask

    task automatic test_threshold();
        load_slots(10, 10, 10, 10, 10, 10, 10, 10);
        thresh = 16'd10;
        run_scan("equal_thresh");
        check_counts("equal_thresh", 0, 1'b0);
        check_read("equal_thresh", 1'b1, 0, '0);
        thresh = 16'd9;
        run_scan("overflow");
        check_counts("overflow", 4, 1'b1);
        for (int i = 0; i < 4; i++)
            check_read("overflow", 1'b1, i, {AW'(i), 16'd10});
    endtask

    task automatic test_host();
        logic [AW+DW-1:0] r;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        sel = 1'b1;
        haddr = 2'd0;
        @(negedge clk);
        tests++;
        if (hdata !== '0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL host_busy_read: got hdata=%h busy=%b expected hdata=0 busy=1", hdata, busy);
        end
        sel = 1'b0;
        repeat (8) @(negedge clk);
        check_read("host_nosel", 1'b0, 1, '0);
        check_read("host_sel", 1'b1, 1, {3'd1, 16'd10});
        do_read(1'b0, 1, r);
    endtask

    task automatic test_back_to_back();
        int since_done = -1;
        int dones = 0;
        int restarts = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                since_done = 0;
            end else if (since_done >= 0) since_done++;
            if (since_done == 1) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy);
                end
            end
            if (since_done == 2) begin
                tests++;
                if (busy !== 1'b1 || hnhit !== '0 || ovf !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_restart: got busy=%b hnhit=%0d ovf=%b expected 1 0 0", busy, hnhit, ovf);
                end else restarts++;
            end
        end
        start = 1'b0;
        tests++;
        if (dones != 2 || restarts != 2) begin
            fails++;
            $display("FAIL b2b_count: got dones=%0d restarts=%0d expected 2 2", dones, restarts);
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        int bad = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (addr !== 3'd4 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (addr !== 3'd4) begin
            fails++;
            $display("FAIL midreset_wait: got addr=%0d expected 4 within budget", addr);
        end
        rst_n = 1'b0;
        sel = 1'b1;
        haddr = 2'd0;
        @(negedge clk);
        tests++;
        if (addr !== '0 || busy !== 1'b0 || done !== 1'b0 || hdata !== '0 ||
            hnhit !== '0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL midreset_values: got addr=%0d busy=%b done=%b hdata=%h hnhit=%0d ovf=%b expected all 0",
                     addr, busy, done, hdata, hnhit, ovf);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || hdata !== '0) bad++;
        end
        sel = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midreset_after: got %0d cycles with done/busy/hdata set expected 0", bad);
        end
    endtask

    initial begin
        load_slots(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_sparse();
        test_threshold();
        test_host();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/readout_scan.md
READOUT_SCAN -- requirements
Module: readout_scan

Interface
REQ-001 Parameter N_SLOTS, 256, number of bus slots scanned per cycle of operation (2..2^AW).
REQ-002 Parameter AW, 8, slot address bus width.
REQ-003 Parameter DW, 16, slot data bus width.
REQ-004 Parameter DEPTH, 256, hit buffer entries (power of two, 2..N_SLOTS).
REQ-005 Parameter HAW, 8, host address width, equal to log2(DEPTH).
REQ-006 The block SHALL use one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  master clock; all state changes on rising edge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 start  in  1  scan request from host.
REQ-010 thresh  in  DW  zero-suppression threshold, unsigned.
REQ-011 addr  out  AW  slot address bus.
REQ-012 data  in  DW  slot data bus, valid one cycle after addr.
REQ-013 sel  in  1  host select.
REQ-014 haddr  in  HAW  hit buffer index from host.
REQ-015 busy  out  1  scan in progress.
REQ-016 done  out  1  one-cycle pulse at scan completion.
REQ-017 hdata  out  AW+DW  hit entry to host, {slot, value}.
REQ-018 hnhit  out  HAW+1  number of stored hits.
REQ-019 ovf  out  1  more hits seen than DEPTH in last scan.

Function
REQ-020 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN when start=1; SCAN->DRAIN after addr=N_SLOTS-1 issued; DRAIN->DONE; DONE->IDLE unconditionally.
REQ-021 start SHALL be ignored in SCAN, DRAIN and DONE; start held high causes a new scan on the IDLE cycle after DONE.
REQ-022 On IDLE->SCAN edge: hnhit cleared to 0, ovf cleared to 0, addr set to 0.
REQ-023 In SCAN addr SHALL increment by 1 per cycle, 0..N_SLOTS-1, exactly N_SLOTS cycles; addr=0 in all other states.
REQ-024 data sampled in cycle k+1 SHALL be attributed to the slot driven in cycle k (evaluation in SCAN cycles 2..N and DRAIN).
REQ-025 Hit = data > thresh (strict unsigned); data == thresh is not a hit.
REQ-026 On a hit with hnhit < DEPTH: store {slot, data} at entry hnhit, increment hnhit on same edge.
REQ-027 On a hit with hnhit == DEPTH: no store, hnhit holds at DEPTH, ovf set and held until next scan start.
REQ-028 busy=1 in SCAN and DRAIN (N_SLOTS+1 cycles); 0 in IDLE and DONE.
REQ-029 done=1 only in DONE state.
REQ-030 hnhit SHALL show the live count at all times; final value valid from DONE onward.
REQ-031 Host read: hdata registered, one-cycle latency; value at edge k+1 = entry[haddr at edge k] when sel=1, busy=0 and haddr < hnhit; else 0.
REQ-032 Entries at index >= hnhit SHALL never be returned; buffer contents need not be cleared.
REQ-033 thresh SHALL be sampled per evaluation; host holds it stable during busy.

Reset
REQ-034 rst_n=0 at a rising edge: state IDLE, addr=0, busy=0, done=0, hdata=0, hnhit=0, ovf=0.
REQ-035 Reset mid-scan SHALL abort immediately with the above values; no done pulse; next scan needs start after reset release.
REQ-036 Hit buffer contents SHALL not require reset.

Verification (N_SLOTS=8, AW=3, DW=16, DEPTH=4, HAW=2)
REQ-037 Slots 0..7 = 0,5,0,9,0,0,7,0, thresh=0, one-cycle start -> busy high 9 cycles, done pulse, hnhit=3, ovf=0, reads 0..2 = {1,5},{3,9},{6,7}, read 3 = 0.
REQ-038 All slots = 10, thresh=10 -> hnhit=0, ovf=0; thresh=9 -> hnhit=4, ovf=1, entries slots 0..3.
REQ-039 start held high 30 cycles -> back-to-back scans, each restarted one IDLE cycle after DONE, hnhit/ovf cleared at each start.
REQ-040 rst_n low at addr=4 -> next edge all outputs at reset values; no done; sel reads return 0.
REQ-041 sel=1 during busy or sel=0 with valid haddr -> hdata=0; sel=1, busy=0, haddr=1 -> entry 1 one cycle later.
